lookup_table_writer: RTL
========================

Name: lookup_table_writer

Overview:
- Control-plane writer that produces the lookup engine's control channel, i.e. the programming end opposite the engine's lookup/action RAM write ports.
- Consumes a 32-bit config-word stream carrying one command per packet.
- Assembles 896-bit key/mask entries and 25-bit action entries.
- Issues single-cycle write strobes for one pipeline stage; packets addressed to other stages are dropped.

Parameters:
- STAGE, 0, stage id this instance accepts (compared to header [27:24]).
- KEY_LEN, 896, CAM key width; must be a multiple of 32.
- MASK_LEN, 896, CAM mask width; must equal KEY_LEN.
- ACTION_LEN, 25, action RAM word width; must be ≤ 32.
- ADDR_W, 4, entry address width (both RAMs).

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- cfg_data  in  32  config word
- cfg_valid  in  1  word valid
- cfg_last  in  1  last word of packet
- cfg_ready  out  1  word accepted when valid&ready
- lookup_din  out  KEY_LEN  CAM key to write
- lookup_din_mask  out  MASK_LEN  CAM mask to write
- lookup_din_addr  out  ADDR_W  CAM entry address
- lookup_din_en  out  1  CAM write strobe
- action_data_in  out  ACTION_LEN  action word
- action_en  out  1  action RAM write strobe
- action_addr  out  ADDR_W  action entry address
- cfg_err  out  1  one-cycle pulse on malformed packet
- err_cnt  out  16  saturating count of cfg_err pulses

Behaviour:
- Reset: every output is 0, including cfg_ready and err_cnt; FSM goes to S_HDR. A reset arriving mid-packet discards the partial entry and issues no strobe. The first word after reset is treated as a header.
- Header word layout:
  - [31:28] opcode: 1 = CAM write, 2 = action write, other = invalid.
  - [27:24] stage.
  - [ADDR_W-1:0] address.
  - All remaining bits are ignored.
- KEY_WORDS = KEY_LEN/32 = 28. Payload order is MS word first; the shift register does acc <= {acc[KEY_LEN-33:0], cfg_data}.
- States:
  - S_HDR: cfg_ready=1. On accept:
    - cfg_last=1 → pulse cfg_err, stay in S_HDR.
    - Stage mismatch → S_DROP, no error.
    - Opcode 1 → S_KEY.
    - Opcode 2 → S_ACT.
    - Invalid opcode → S_DROP with cfg_err.
    - Latch the address; clear word_cnt.
  - S_KEY: cfg_ready=1. Shift words into the key accumulator and increment word_cnt. After word KEY_WORDS, go to S_MASK and clear word_cnt. cfg_last on any key word → cfg_err, S_HDR.
  - S_MASK: cfg_ready=1. Shift words into the mask accumulator.
    - Word KEY_WORDS with cfg_last=1 → S_COMMIT.
    - Word KEY_WORDS with cfg_last=0 → cfg_err, S_DROP.
    - Earlier cfg_last → cfg_err, S_HDR.
  - S_ACT: cfg_ready=1. First word with cfg_last=1 → latch cfg_data[ACTION_LEN-1:0], S_COMMIT. Without cfg_last → cfg_err, S_DROP.
  - S_COMMIT: cfg_ready=0 for exactly one cycle. Drive the registered outputs and pulse lookup_din_en or action_en. Return to S_HDR.
  - S_DROP: cfg_ready=1. Discard words until an accepted cfg_last, then S_HDR. No strobes are issued.
- Latency: the strobe is asserted in the cycle after the last payload word is accepted. Data and address outputs change only on commit and hold stable until the next commit of the same type. A CAM commit leaves the action outputs untouched, and vice versa.
- Strobes are exactly one cycle wide; never both in the same cycle.
- cfg_valid gaps are allowed anywhere; state and word_cnt advance only on accept.
- Incomplete entries never reach the outputs. Accumulators are internal; outputs load from them only in S_COMMIT.
- err_cnt increments on each cfg_err pulse and saturates at 16'hFFFF.

Decomposition:
- Package lookup_cfg_pkg:
  - opcode constants OP_CAM=4'd1, OP_ACT=4'd2;
  - FSM state encoding;
  - KEY_WORDS;
  - header field bit positions.
- Sub-module cfg_word_assembler: parameterised WIDTH shift accumulator with load/clear and word counter, instantiated twice (key, mask).

Test Plan:
- CAM write: header {4'h1, STAGE, addr=3}, 28 key words forming {8'hff,888'h0}, then 28 mask words of 32'hFFFFFFFF with last on the final word. Required: lookup_din_en high exactly 1 cycle, one cycle after the last accept; lookup_din={8'hff,888'h0}; mask all ones; lookup_din_addr=3; cfg_ready=0 in that cycle.
- Action write: header {4'h2, STAGE, addr=5}, then payload 32'h00123456 with last. Required: action_en 1-cycle pulse; action_data_in=25'h0123456; action_addr=5; CAM outputs unchanged.
- Stage mismatch: header stage=STAGE+1, followed by a full CAM packet. Required: no strobes, cfg_err=0. A following valid action packet commits normally.
- Malformed packets:
  - cfg_last on mask word 10 → cfg_err pulse, no strobe, err_cnt=1.
  - Mask word 28 without last → cfg_err, words dropped through the next last, err_cnt=2.
- Backpressure and idle gaps: repeat the CAM write with cfg_valid toggled randomly. Required: result identical to the first scenario.
- Reset mid-packet: aresetn low for 1 cycle after key word 12. Required: all outputs 0, no strobe. A subsequent clean action packet commits correctly.

Source files
------------

// File: rtl/lookup_cfg_pkg.sv
// Shared constants, header field positions and FSM encoding for the
// lookup table config writer.
package lookup_cfg_pkg;

    localparam int CFG_W       = 32;
    localparam int DEF_KEY_LEN = 896;
    localparam int KEY_WORDS   = DEF_KEY_LEN / CFG_W;

    localparam logic [3:0] OP_CAM = 4'd1;
    localparam logic [3:0] OP_ACT = 4'd2;

    // Header layout: [31:28] opcode, [27:24] stage, [ADDR_W-1:0] address.
    localparam int HDR_OP_LSB    = 28;
    localparam int HDR_STAGE_LSB = 24;

    typedef enum logic [2:0] {
        S_HDR    = 3'd0,
        S_KEY    = 3'd1,
        S_MASK   = 3'd2,
        S_ACT    = 3'd3,
        S_COMMIT = 3'd4,
        S_DROP   = 3'd5
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Shift accumulator that builds a WIDTH-bit entry from 32-bit words, most
// significant word first, and counts the words shifted in since the last clear.
module cfg_word_assembler
    import lookup_cfg_pkg::*;
#(
    parameter int WIDTH = DEF_KEY_LEN,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic [31:0]      din,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] acc_q, acc_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    generate
        if (WIDTH > CFG_W) begin : g_wide
            assign shifted = {acc_q[WIDTH-CFG_W-1:0], din};
        end else begin : g_narrow
            assign shifted = din[WIDTH-1:0];
        end
    endgenerate

    // Next accumulator/count: clear wins over shift.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (shift) begin
            acc_d = shifted;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register the accumulator and word count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // The look-ahead value lets the commit load the word accepted this cycle.
    assign acc_nxt = acc_d;
    assign cnt     = cnt_q;

endmodule

// File: rtl/lookup_table_writer.sv
// Config-stream writer: parses one command per packet and issues single-cycle
// CAM key/mask or action RAM writes for this pipeline stage only.
module lookup_table_writer
    import lookup_cfg_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int KEY_LEN    = KEY_WORDS * CFG_W,
    parameter int MASK_LEN   = KEY_LEN,
    parameter int ACTION_LEN = 25,
    parameter int ADDR_W     = 4
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [31:0]           cfg_data,
    input  logic                  cfg_valid,
    input  logic                  cfg_last,
    output logic                  cfg_ready,
    output logic [KEY_LEN-1:0]    lookup_din,
    output logic [MASK_LEN-1:0]   lookup_din_mask,
    output logic [ADDR_W-1:0]     lookup_din_addr,
    output logic                  lookup_din_en,
    output logic [ACTION_LEN-1:0] action_data_in,
    output logic                  action_en,
    output logic [ADDR_W-1:0]     action_addr,
    output logic                  cfg_err,
    output logic [15:0]           err_cnt
);

    localparam int NWORDS = KEY_LEN / CFG_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
    localparam logic [3:0]       STAGE_ID = 4'(STAGE);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic [KEY_LEN-1:0]    din_q, din_d;
    logic [MASK_LEN-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]     laddr_q, laddr_d;
    logic                  len_q, len_d;
    logic [ACTION_LEN-1:0] act_q, act_d;
    logic                  aen_q, aen_d;
    logic [ADDR_W-1:0]     aaddr_q, aaddr_d;
    logic                  err_q, err_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic                  accept, err_now;
    logic                  key_clr, key_shift, mask_clr, mask_shift;
    logic [KEY_LEN-1:0]    key_nxt;
    logic [MASK_LEN-1:0]   mask_nxt;
    logic [CNT_W-1:0]      key_cnt, mask_cnt;
    logic [3:0]            hdr_op, hdr_stage;

    assign accept    = cfg_valid & cfg_ready_q;
    assign hdr_op    = cfg_data[HDR_OP_LSB +: 4];
    assign hdr_stage = cfg_data[HDR_STAGE_LSB +: 4];

    cfg_word_assembler #(.WIDTH(KEY_LEN), .CNT_W(CNT_W)) u_key (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .clr     (key_clr),
        .shift   (key_shift),
        .din     (cfg_data),
        .acc_nxt (key_nxt),
        .cnt     (key_cnt)
    );

    cfg_word_assembler #(.WIDTH(MASK_LEN), .CNT_W(CNT_W)) u_mask (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .clr     (mask_clr),
        .shift   (mask_shift),
        .din     (cfg_data),
        .acc_nxt (mask_nxt),
        .cnt     (mask_cnt)
    );

    // Packet parser: next state, assembler control and the commit loads that
    // make the strobe and its data appear together the cycle after the last word.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        mask_d     = mask_q;
        laddr_d    = laddr_q;
        len_d      = 1'b0;
        act_d      = act_q;
        aen_d      = 1'b0;
        aaddr_d    = aaddr_q;
        err_now    = 1'b0;
        key_clr    = 1'b0;
        key_shift  = 1'b0;
        mask_clr   = 1'b0;
        mask_shift = 1'b0;

        case (state_q)
            S_HDR: if (accept) begin
                key_clr  = 1'b1;
                mask_clr = 1'b1;
                addr_d   = cfg_data[ADDR_W-1:0];
                if (cfg_last) begin
                    err_now = 1'b1;
                end else if (hdr_stage != STAGE_ID) begin
                    state_d = S_DROP;
                end else if (hdr_op == OP_CAM) begin
                    state_d = S_KEY;
                end else if (hdr_op == OP_ACT) begin
                    state_d = S_ACT;
                end else begin
                    err_now = 1'b1;
                    state_d = S_DROP;
                end
            end
            S_KEY: if (accept) begin
                key_shift = 1'b1;
                if (cfg_last) begin
                    err_now = 1'b1;
                    state_d = S_HDR;
                end else if (key_cnt == LAST_IDX) begin
                    state_d = S_MASK;
                end
            end
            S_MASK: if (accept) begin
                mask_shift = 1'b1;
                if (mask_cnt == LAST_IDX) begin
                    if (cfg_last) begin
                        state_d = S_COMMIT;
                        len_d   = 1'b1;
                        din_d   = key_nxt;
                        mask_d  = mask_nxt;
                        laddr_d = addr_q;
                    end else begin
                        err_now = 1'b1;
                        state_d = S_DROP;
                    end
                end else if (cfg_last) begin
                    err_now = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_ACT: if (accept) begin
                if (cfg_last) begin
                    state_d = S_COMMIT;
                    aen_d   = 1'b1;
                    act_d   = cfg_data[ACTION_LEN-1:0];
                    aaddr_d = addr_q;
                end else begin
                    err_now = 1'b1;
                    state_d = S_DROP;
                end
            end
            S_COMMIT: state_d = S_HDR;
            S_DROP: if (accept && cfg_last) state_d = S_HDR;
            default: state_d = S_HDR;
        endcase

        cfg_ready_d = (state_d != S_COMMIT);
        err_d       = err_now;
        err_cnt_d   = err_now ? sat_inc16(err_cnt_q) : err_cnt_q;
    end

    // State and registered outputs; reset drops any partial entry.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q     <= S_HDR;
            addr_q      <= '0;
            cfg_ready_q <= 1'b0;
            din_q       <= '0;
            mask_q      <= '0;
            laddr_q     <= '0;
            len_q       <= 1'b0;
            act_q       <= '0;
            aen_q       <= 1'b0;
            aaddr_q     <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cfg_ready_q <= cfg_ready_d;
            din_q       <= din_d;
            mask_q      <= mask_d;
            laddr_q     <= laddr_d;
            len_q       <= len_d;
            act_q       <= act_d;
            aen_q       <= aen_d;
            aaddr_q     <= aaddr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cfg_ready       = cfg_ready_q;
    assign lookup_din      = din_q;
    assign lookup_din_mask = mask_q;
    assign lookup_din_addr = laddr_q;
    assign lookup_din_en   = len_q;
    assign action_data_in  = act_q;
    assign action_en       = aen_q;
    assign action_addr     = aaddr_q;
    assign cfg_err         = err_q;
    assign err_cnt         = err_cnt_q;

endmodule
